// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus constants and the OAM DMA state encoding.
package nes_bus_pkg;

  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
  localparam int unsigned XFER_LEN      = 256;
  localparam logic [7:0]  LAST_IDX      = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } oam_dma_state_t;

endpackage

// File: rtl/oam_dma_controller_if.sv
// CPU-side bus signals seen by the OAM DMA and the DMA bus-master outputs.
interface oam_dma_controller_if;

  logic        cycle_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_rw_n;
  logic [7:0]  bus_data_in;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rw_n;
  logic [7:0]  dma_data_out;

  modport master (
    output cycle_en, cpu_addr, cpu_data_out, cpu_rw_n, bus_data_in,
    input  cpu_rdy, dma_active, dma_addr, dma_rw_n, dma_data_out
  );

  modport slave (
    input  cycle_en, cpu_addr, cpu_data_out, cpu_rw_n, bus_data_in,
    output cpu_rdy, dma_active, dma_addr, dma_rw_n, dma_data_out
  );

endinterface

// File: rtl/oam_dma_controller_seq.sv
// OAM DMA sequencer: state, get/put parity and byte index; advances only on cycle_en.
//
// state | meaning
// IDLE  | CPU owns the bus, waiting for a $4014 write
// HALT  | CPU halted, dummy read cycle
// ALIGN | extra dummy read so that READ lands on a get cycle
// READ  | read byte {page, idx}
// WRITE | write latched byte to $2004
module oam_dma_controller_seq
  import nes_bus_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           cycle_en,
  input  logic           trigger,
  output oam_dma_state_t state_q,
  output oam_dma_state_t state_d,
  output logic [7:0]     idx_d
);

  logic [7:0] idx_q;
  logic       parity_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      parity_q <= 1'b0;
    end else if (cycle_en) begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      parity_q <= ~parity_q;
    end
  end

  // parity_q describes the cycle now in progress; a put HALT is followed by a get cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = HALT;
          idx_d   = '0;
        end
      end
      HALT:  state_d = parity_q ? READ : ALIGN;
      ALIGN: state_d = READ;
      READ:  state_d = WRITE;
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/oam_dma_controller.sv
// OAM DMA controller top: page/data latches and registered bus-master outputs.
module oam_dma_controller
  import nes_bus_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  oam_dma_controller_if.slave   bus
);

  oam_dma_state_t state_q;
  oam_dma_state_t state_d;
  logic [7:0]     idx_d;
  logic [7:0]     page_q;
  logic [7:0]     page_d;
  logic [7:0]     latch_q;
  logic [7:0]     latch_d;
  logic           trigger;

  logic           cpu_rdy_q;
  logic           dma_active_q;
  logic [15:0]    dma_addr_q;
  logic           dma_rw_n_q;
  logic [7:0]     dma_data_out_q;

  assign trigger = !bus.cpu_rw_n && (bus.cpu_addr == DMA_REG_ADDR);
  assign page_d  = ((state_q == IDLE) && trigger) ? bus.cpu_data_out : page_q;
  assign latch_d = (state_q == READ) ? bus.bus_data_in : latch_q;

  oam_dma_controller_seq u_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .cycle_en (bus.cycle_en),
    .trigger  (trigger),
    .state_q  (state_q),
    .state_d  (state_d),
    .idx_d    (idx_d)
  );

  // Outputs are registered from the next state so they describe the bus cycle that follows the tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      page_q         <= '0;
      latch_q        <= '0;
      cpu_rdy_q      <= 1'b1;
      dma_active_q   <= 1'b0;
      dma_addr_q     <= '0;
      dma_rw_n_q     <= 1'b1;
      dma_data_out_q <= '0;
    end else if (bus.cycle_en) begin
      page_q       <= page_d;
      latch_q      <= latch_d;
      cpu_rdy_q    <= (state_d == IDLE);
      dma_active_q <= (state_d != IDLE);
      case (state_d)
        IDLE: begin
          dma_addr_q     <= '0;
          dma_rw_n_q     <= 1'b1;
          dma_data_out_q <= '0;
        end
        WRITE: begin
          dma_addr_q     <= OAM_DATA_ADDR;
          dma_rw_n_q     <= 1'b0;
          dma_data_out_q <= latch_d;
        end
        default: begin
          dma_addr_q     <= {page_d, idx_d};
          dma_rw_n_q     <= 1'b1;
          dma_data_out_q <= '0;
        end
      endcase
    end
  end

  assign bus.cpu_rdy      = cpu_rdy_q;
  assign bus.dma_active   = dma_active_q;
  assign bus.dma_addr     = dma_addr_q;
  assign bus.dma_rw_n     = dma_rw_n_q;
  assign bus.dma_data_out = dma_data_out_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench for oam_dma_controller: queue-of-bus-cycles model plus literal checks.
module tb_oam_dma_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  oam_dma_controller_if bus_if ();

  oam_dma_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  logic [7:0] mem [0:65535];
  assign bus_if.bus_data_in = mem[bus_if.dma_addr];

  typedef struct packed {
    logic        rdy;
    logic        act;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  data;
  } cyc_t;

  cyc_t        exp_q [$];
  int unsigned tick_cnt = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  int          rdy_low;
  int          n_writes;
  logic [15:0] last_rd;
  logic [7:0]  first_wr;
  bit          zero_hit;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_assert++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, req);
    end
  endtask

  function automatic cyc_t mk(input logic rdy, input logic act, input logic [15:0] addr,
                              input logic rw, input logic [7:0] data);
    cyc_t c;
    c.rdy = rdy; c.act = act; c.addr = addr; c.rw = rw; c.data = data;
    return c;
  endfunction

  // Whole transfer expressed as the list of bus cycles it must produce
  function automatic void build(input logic [7:0] page, input bit align);
    exp_q.push_back(mk(1'b0, 1'b1, {page, 8'h00}, 1'b1, 8'h00));
    if (align) exp_q.push_back(mk(1'b0, 1'b1, {page, 8'h00}, 1'b1, 8'h00));
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      a = {page, 8'(i)};
      exp_q.push_back(mk(1'b0, 1'b1, a, 1'b1, 8'h00));
      exp_q.push_back(mk(1'b0, 1'b1, 16'h2004, 1'b0, mem[a]));
    end
  endfunction

  function automatic void model_tick(input logic [15:0] a, input logic [7:0] d, input logic rw);
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else if (!rw && a == 16'h4014) begin
      // HALT is the next cycle; cycle k is a get cycle when k is even
      build(d, ((tick_cnt + 1) % 2) == 0);
    end
    tick_cnt++;
  endfunction

  task automatic compare();
    cyc_t e, g;
    e = (exp_q.size() == 0) ? mk(1'b1, 1'b0, 16'h0000, 1'b1, 8'h00) : exp_q[0];
    g = {bus_if.cpu_rdy, bus_if.dma_active, bus_if.dma_addr, bus_if.dma_rw_n, bus_if.dma_data_out};
    n_assert++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t: got rdy=%b act=%b addr=%h rw=%b data=%h, expected rdy=%b act=%b addr=%h rw=%b data=%h",
               $time, g.rdy, g.act, g.addr, g.rw, g.data, e.rdy, e.act, e.addr, e.rw, e.data);
    end
  endtask

  task automatic clk_cycle(input bit en, input logic [15:0] a, input logic [7:0] d, input logic rw);
    bus_if.cycle_en     = en;
    bus_if.cpu_addr     = a;
    bus_if.cpu_data_out = d;
    bus_if.cpu_rw_n     = rw;
    if (en) begin
      if (!bus_if.cpu_rdy) rdy_low++;
      if (bus_if.dma_active && !bus_if.dma_rw_n) begin
        if (n_writes == 0) first_wr = bus_if.dma_data_out;
        n_writes++;
      end
      if (bus_if.dma_active && bus_if.dma_rw_n) last_rd = bus_if.dma_addr;
      if (bus_if.dma_active && bus_if.dma_addr == 16'h0000) zero_hit = 1'b1;
    end
    @(posedge clk);
    #1;
    if (en) model_tick(a, d, rw);
    @(negedge clk);
    compare();
  endtask

  task automatic rand_cycle(input bit en, input bit allow_trig);
    logic [15:0] a;
    logic        rw;
    a  = 16'($urandom);
    rw = 1'($urandom);
    if ($urandom_range(0, 7) == 0) begin
      a  = 16'h4014;
      rw = 1'b0;
    end
    if (!allow_trig && !rw && a == 16'h4014) a = 16'h4015;
    clk_cycle(en, a, 8'($urandom), rw);
  endtask

  task automatic tick(input bit gapped, input bit allow_trig);
    if (gapped) repeat ($urandom_range(0, 5)) rand_cycle(1'b0, 1'b1);
    rand_cycle(1'b1, allow_trig);
  endtask

  task automatic clear_stats();
    rdy_low = 0; n_writes = 0; last_rd = 16'h0; first_wr = 8'h0; zero_hit = 1'b0;
  endtask

  task automatic start_xfer(input logic [7:0] page, input bit want_align, input bit gapped);
    int guard;
    guard = 0;
    while ((((tick_cnt + 1) % 2) == 0) != want_align && guard < 4) begin
      tick(gapped, 1'b0);
      guard++;
    end
    if (gapped) repeat ($urandom_range(0, 5)) rand_cycle(1'b0, 1'b0);
    clk_cycle(1'b1, 16'h4014, page, 1'b0);
    clear_stats();
  endtask

  task automatic finish_xfer(input string name, input bit gapped);
    for (int k = 0; k < 6000 && exp_q.size() != 0; k++) tick(gapped, 1'b1);
    check({name, "_timeout"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    bus_if.cycle_en = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("rst_rdy", bus_if.cpu_rdy, 1);
    check("rst_active", bus_if.dma_active, 0);
    check("rst_addr", bus_if.dma_addr, 16'h0000);
    check("rst_rw", bus_if.dma_rw_n, 1);
    check("rst_data", bus_if.dma_data_out, 8'h00);
    exp_q.delete();
    tick_cnt = 0;
    @(negedge clk);
    compare();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bit al;
    logic [7:0] pg;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    bus_if.cycle_en = 1'b0; bus_if.cpu_addr = 16'h0; bus_if.cpu_data_out = 8'h0; bus_if.cpu_rw_n = 1'b1;
    clear_stats();
    do_reset();

    // Non-triggering accesses: read of $4014, write $4015, $4014 write without a tick
    clk_cycle(1'b1, 16'h4014, 8'h07, 1'b1);
    clk_cycle(1'b1, 16'h4015, 8'h07, 1'b0);
    repeat (3) clk_cycle(1'b0, 16'h4014, 8'h07, 1'b0);
    clk_cycle(1'b1, 16'h4000, 8'h07, 1'b1);
    repeat (10) tick(1'b0, 1'b0);
    check("no_trig_rdy", bus_if.cpu_rdy, 1);

    // HALT on a put cycle
    start_xfer(8'h02, 1'b0, 1'b0);
    finish_xfer("put_halt", 1'b0);
    check("put_halt_len", rdy_low, 513);
    check("put_halt_writes", n_writes, 256);
    check("put_halt_first_data", first_wr, 8'h5A);
    check("put_halt_last_rd", last_rd, 16'h02FF);
    check("put_halt_rdy_after", bus_if.cpu_rdy, 1);

    // HALT on a get cycle needs one ALIGN
    start_xfer(8'h02, 1'b1, 1'b0);
    finish_xfer("get_halt", 1'b0);
    check("get_halt_len", rdy_low, 514);
    check("get_halt_writes", n_writes, 256);

    // Irregular CYCLE_EN spacing
    start_xfer(8'h02, 1'b0, 1'b1);
    finish_xfer("gapped", 1'b1);
    check("gapped_len", rdy_low, 513);
    check("gapped_first_data", first_wr, 8'h5A);

    // Top page does not wrap
    start_xfer(8'hFF, 1'b1, 1'b0);
    finish_xfer("page_ff", 1'b0);
    check("page_ff_last_rd", last_rd, 16'hFFFF);
    check("page_ff_zero_access", zero_hit, 0);
    check("page_ff_len", rdy_low, 514);

    // Reset after the 100th write abandons the transfer
    start_xfer(8'h04, 1'b0, 1'b0);
    for (int k = 0; k < 1000 && n_writes < 100; k++) tick(1'b0, 1'b1);
    check("mid_rst_reached", n_writes, 100);
    do_reset();
    repeat (20) tick(1'b0, 1'b0);
    check("mid_rst_no_more_writes", n_writes, 100);
    start_xfer(8'h03, 1'b1, 1'b0);
    finish_xfer("after_rst", 1'b0);
    check("after_rst_len", rdy_low, 514);
    check("after_rst_first_data", first_wr, mem[16'h0300]);

    // Random pages, alignment and spacing
    for (int n = 0; n < 4; n++) begin
      pg = 8'($urandom);
      al = 1'($urandom);
      start_xfer(pg, al, 1'($urandom));
      finish_xfer("rand", 1'b1);
      check("rand_len", rdy_low, al ? 514 : 513);
      check("rand_last_rd", last_rd, {pg, 8'hFF});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
